// File: rtl/sd_pkg.sv
// Shared constants for the sigma-delta receive path: CIC order, accumulator
// width rule and the bitstream-to-+/-1 mapping.
package sd_pkg;

    localparam int CIC_ORDER  = 3;
    localparam int SD_BIT_POS = 1;
    localparam int SD_BIT_NEG = -1;

    // One bit of headroom above the R^3 gain plus the sign bit.
    function automatic int cic_accw(input int log2r);
        return CIC_ORDER * log2r + 2;
    endfunction

endpackage

// File: rtl/sd_cic_integ.sv
// Single enabled, wrapping integrator stage of the CIC decimator.
module sd_cic_integ #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] acc
);

    logic signed [W-1:0] acc_d, acc_q;

    // Modulo 2^W wrap is what makes the CIC exact; never saturate here.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator (R = 2^LOG2R) for a 1-bit sigma-delta stream with
// overwrite-on-stall output. Optional drop counter: SD_DECIM_DROPCNT_EN.
module sd_cic_decimator
    import sd_pkg::*;
#(
    parameter int LOG2R = 6,
    parameter int OUTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic signed [OUTW-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ovf,
    input  logic                   ovf_clr
`ifdef SD_DECIM_DROPCNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int ACCW = cic_accw(LOG2R);

    function automatic logic signed [OUTW-1:0] scale_out(input logic signed [ACCW-1:0] v);
        return $signed(v[ACCW-1 -: OUTW]);
    endfunction

    logic signed [ACCW-1:0] x_p0;
    logic signed [ACCW-1:0] i1, i2, i3;
    logic [LOG2R-1:0]       phase_d, phase_q;
    logic                   strobe_p0;
    logic                   vld_p1_d, vld_p1_q;
    logic                   vld_p2_d, vld_p2_q;
    logic signed [ACCW-1:0] c1, c2, c3;
    logic signed [ACCW-1:0] d1_d, d1_q, d2_d, d2_q, d3_d, d3_q;
    logic signed [OUTW-1:0] comb_p2_d, comb_p2_q;
    logic signed [OUTW-1:0] out_data_d, out_data_q;
    logic                   out_valid_d, out_valid_q;
    logic                   ovf_d, ovf_q;
    logic                   ovf_set;

    // Stage p0: bit mapping, integrators and decimation phase
    assign x_p0 = in_bit ? ACCW'(SD_BIT_POS) : ACCW'(SD_BIT_NEG);

    sd_cic_integ #(.W(ACCW)) u_integ1 (
        .clk   (clk),
        .rst_n (reset),
        .en    (in_valid),
        .din   (x_p0),
        .acc   (i1)
    );

    sd_cic_integ #(.W(ACCW)) u_integ2 (
        .clk   (clk),
        .rst_n (reset),
        .en    (in_valid),
        .din   (i1),
        .acc   (i2)
    );

    sd_cic_integ #(.W(ACCW)) u_integ3 (
        .clk   (clk),
        .rst_n (reset),
        .en    (in_valid),
        .din   (i2),
        .acc   (i3)
    );

    always_comb begin
        strobe_p0 = in_valid && (phase_q == '1);
        phase_d   = in_valid ? phase_q + LOG2R'(1) : phase_q;
        vld_p1_d  = strobe_p0;
    end

    // Stage p1: comb cascade on the captured I3, delays advance only on strobes
    always_comb begin
        c1        = i3 - d1_q;
        c2        = c1 - d2_q;
        c3        = c2 - d3_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        comb_p2_d = comb_p2_q;
        if (vld_p1_q) begin
            d1_d      = i3;
            d2_d      = c1;
            d3_d      = c2;
            comb_p2_d = scale_out(c3);
        end
        vld_p2_d = vld_p1_q;
    end

    // Stage p2: output register with overwrite-on-stall
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_set     = vld_p2_q && out_valid_q && !out_ready;
        if (vld_p2_q) begin
            out_data_d  = comb_p2_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q     <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            comb_p2_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            comb_p2_q   <= comb_p2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

`ifdef SD_DECIM_DROPCNT_EN
    logic [15:0] drop_cnt_d, drop_cnt_q;

    // A clear coinciding with a drop leaves exactly that one drop counted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_set) begin
            if (ovf_clr) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Directed bench for sd_cic_decimator (default R=64 instance plus an R=256 instance).
module tb_sd_cic_decimator;

    localparam int R  = 64;
    localparam int R8 = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    logic        in_valid2 = 1'b0;
    logic        in_bit2 = 1'b0;
    logic [15:0] out_data2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic        ovf2;
    logic        ovf_clr2 = 1'b0;
`ifdef SD_DECIM_DROPCNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt2;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] samples[$];

    always #5 clk = ~clk;

    sd_cic_decimator #(.LOG2R(6), .OUTW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef SD_DECIM_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    sd_cic_decimator #(.LOG2R(8), .OUTW(16)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_bit    (in_bit2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .ovf       (ovf2),
        .ovf_clr   (ovf_clr2)
`ifdef SD_DECIM_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt2)
`endif
    );

    // Each accepted sample is recorded half a cycle before the accepting edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            samples.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = zeros, 1 = ones, 2 = alternating starting with 1
    task automatic feed(input int mode, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = (mode == 2) ? ((i % 2) == 0) : (mode == 1);
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        samples.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_init got v=%b d=%h o=%b exp v=0 d=0000 o=0", out_valid, out_data, ovf);
        end
`ifdef SD_DECIM_DROPCNT_EN
        checks++;
        if (drop_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL reset_drop got %h exp 0000", drop_cnt);
        end
`endif
        reset = 1'b1;
        out_ready = 1'b0;
        feed(1, R + R / 2, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL prereset_valid got %b exp 1", out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got v=%b d=%h o=%b exp v=0 d=0000 o=0", out_valid, out_data, ovf);
        end
        tick();
        for (int i = 0; i < R; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL valid_in_reset cycle %0d got %b exp 0", i, out_valid);
            end
        end
        in_valid  = 1'b0;
        reset     = 1'b1;
        out_ready = 1'b1;
        samples.delete();
        feed(1, 4 * R, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_t0 got %b exp 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_t1 got %b exp 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4000) begin
            failures++;
            $display("FAIL latency_t2 got v=%b d=%h exp v=1 d=4000", out_valid, out_data);
        end
        repeat (3) tick();
        checks++;
        if (samples.size() !== 4) begin
            failures++;
            $display("FAIL reset_sample_count got %0d exp 4", samples.size());
        end else if (samples[3] !== 16'h4000) begin
            failures++;
            $display("FAIL reset_sample4 got %h exp 4000", samples[3]);
        end
    endtask

    task automatic test_pattern(input string name, input int mode, input int gap, input logic [15:0] exp);
        do_reset();
        out_ready = 1'b1;
        feed(mode, 5 * R, gap);
        repeat (4) tick();
        checks++;
        if (samples.size() !== 5) begin
            failures++;
            $display("FAIL %s_count got %0d exp 5", name, samples.size());
        end else begin
            for (int k = 3; k < 5; k++) begin
                checks++;
                if (samples[k] !== exp) begin
                    failures++;
                    $display("FAIL %s_sample%0d got %h exp %h", name, k + 1, samples[k], exp);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b1;
        feed(0, 4 * R, 0);
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drained got %b exp 0", out_valid);
        end
        out_ready = 1'b0;
        feed(1, R, 0);
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first_load got v=%b o=%b exp v=1 o=0", out_valid, ovf);
        end
        feed(1, 3 * R, 0);
        repeat (2) tick();
        checks++;
        if (ovf !== 1'b1 || out_data !== 16'h4000) begin
            failures++;
            $display("FAIL ovf_overwrite got o=%b d=%h exp o=1 d=4000", ovf, out_data);
        end
`ifdef SD_DECIM_DROPCNT_EN
        checks++;
        if (drop_cnt !== 16'd3) begin
            failures++;
            $display("FAIL drop_cnt_three got %0d exp 3", drop_cnt);
        end
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h4000) begin
            failures++;
            $display("FAIL ovf_clear got o=%b v=%b d=%h exp o=0 v=1 d=4000", ovf, out_valid, out_data);
        end
`ifdef SD_DECIM_DROPCNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL drop_cnt_clear got %0d exp 0", drop_cnt);
        end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ready_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        feed(1, 2 * R, 0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (ovf !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ready_on_load got o=%b v=%b exp o=0 v=1", ovf, out_valid);
        end
        feed(1, R, 0);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clear got %b exp 1", ovf);
        end
`ifdef SD_DECIM_DROPCNT_EN
        checks++;
        if (drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL drop_cnt_coincide got %0d exp 1", drop_cnt);
        end
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_after_coincide got %b exp 0", ovf);
        end
    endtask

    task automatic test_log2r8();
        do_reset();
        for (int i = 0; i < 4 * R8; i++) begin
            in_valid2 = 1'b1;
            in_bit2   = 1'b1;
            tick();
        end
        in_valid2 = 1'b0;
        tick();
        checks++;
        if (out_valid2 !== 1'b0) begin
            failures++;
            $display("FAIL r256_t1 got %b exp 0", out_valid2);
        end
        tick();
        checks++;
        if (out_valid2 !== 1'b1 || out_data2 !== 16'h4000 || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL r256_sample4 got v=%b d=%h o=%b exp v=1 d=4000 o=0", out_valid2, out_data2, ovf2);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_pattern("zeros", 0, 0, 16'hC000);
        test_pattern("alt", 2, 0, 16'h0000);
        test_pattern("gapped", 1, 2, 16'h4000);
        test_overflow();
        test_back_to_back();
        test_log2r8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_cic_decimator.md
# sd_cic_decimator

Third-order CIC decimation filter that turns the 1-bit sigma-delta bitstream back into multi-bit PCM samples. It sits on the receive side of the sigma-delta path and consumes a qualified bitstream (bit 1 = +1, bit 0 = −1, the same mapping as the modulator's ±feedback). It decimates by 2^LOG2R and delivers signed samples over a valid/ready interface with overwrite-on-stall and a sticky overflow flag.

## Interface
- LOG2R, 6, log2 of decimation ratio R (R = 64 default); legal 2..10
- OUTW, 16, output sample width (signed); must be ≤ ACCW
- ACCW (localparam), 3*LOG2R+2, integrator/comb width (20 for defaults)
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_valid  in  1  qualifies in_bit for one cycle
- in_bit  in  1  bitstream input; 1 → +1, 0 → −1
- out_data  out  OUTW  signed decimated sample
- out_valid  out  1  out_data holds an unconsumed sample
- out_ready  in  1  consumer accepts when out_valid & out_ready
- ovf  out  1  sticky: a sample was overwritten before being consumed
- ovf_clr  in  1  synchronous clear of ovf
- drop_cnt  out  16  dropped-sample count (only with SD_DECIM_DROPCNT_EN)

## Operation
- Input mapped to ACCW-bit signed ±1.
- Three cascaded integrators I1..I3 update only on in_valid; wrap-around (modulo 2^ACCW) is intended and must not saturate.
- Phase counter (LOG2R bits) increments on each in_valid and wraps from R−1 to 0. The in_valid that wraps it is the decimation strobe.
- On the cycle after the strobe, I3 is captured and passed through three combs (y = x − x_prev; differential delay 1), each also modulo 2^ACCW. Comb delay registers advance only on decimation strobes.
- Output value = comb3 result arithmetically shifted right by ACCW−OUTW (top OUTW bits). Full-scale +1 gives +R^3 = 2^(3·LOG2R). With defaults, all-ones settles to 0x4000, all-zeros to 0xC000, and 1010… to 0x0000.
- Output register handling:
  - New sample while out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load it, out_valid=1, no overflow.
  - New sample while out_valid=1 and out_ready=0: overwrite out_data and set ovf.
  - out_ready=1 with no new sample: out_valid=0.
- ovf_clr clears ovf. If a set and a clear occur in the same cycle, the set wins.
- Reset values: out_data=0, out_valid=0, ovf=0, drop_cnt=0; integrators, combs and phase counter are 0.
- Reset asserted mid-decimation discards the partial frame. The first strobe after release is the R-th in_valid after release.

## Timing
- Integrators: register updates on the edge that samples in_valid.
- Edge t accepts the R-th bit (strobe). Edge t+1 captures the comb pipeline. Edge t+2 loads the output, so out_valid is high after t+2: 2-cycle latency.
- in_valid may be asserted every cycle. Back-to-back strobes are impossible because R ≥ 4.
- Settling: the first 3 output samples after reset are transient. From the 4th sample on, output is the exact steady-state value for a constant input.
- out_data is stable while out_valid=1 and out_ready=0, except on overwrite.

## Configuration
- SD_DECIM_DROPCNT_EN defined: drop_cnt port present. It increments on every overwrite, saturates at 0xFFFF, and is cleared by reset and by ovf_clr. If an increment and ovf_clr coincide, the result is 1.
- Not defined: the drop_cnt port and counter are absent; ovf behaves identically.

## Structure
- Shared package sd_pkg:
  - CIC_ORDER = 3
  - ACCW computation function
  - bit-to-±1 mapping constants
- One sub-module, sd_cic_integ: a single enabled ACCW-wide wrapping integrator, instantiated three times. Combs, phase counter and output handshake stay inline.

## Test plan
- Reset low mid-stream, then release. Feed 4R ones with out_ready=1 → out_valid=0 throughout reset; the 4th sample is 0x4000 and arrives exactly 2 cycles after the 4R-th in_valid.
- All-zeros bitstream, 5R bits → samples 4–5 equal 0xC000. Alternating 1,0 bitstream → samples 4+ equal 0x0000.
- in_valid gapped (1 of every 3 cycles), constant ones → identical sample values to the ungapped case; the phase counter counts only valid bits.
- out_ready=0 across two strobes → ovf=1, out_data holds the second sample; with SD_DECIM_DROPCNT_EN, drop_cnt=1. Then ovf_clr → ovf=0 and drop_cnt=0.
- out_ready=1 on the exact cycle a new sample loads → ovf stays 0 and out_valid stays 1. Also drive ovf_clr coincident with an overwrite → ovf=1.
- LOG2R=4, constant ones → steady output = 2^12 >> (14−16 → ACCW=14 < OUTW illegal); instead run LOG2R=8, OUTW=16 → ACCW=26, steady 2^24>>10 = 0x4000.
